// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for the single-ported data memory. It holds each access for LAT cycles and then pulses done with rdata.
// Optional round-robin tie-break is enabled by defining MEM_ARB_RR_EN; without it port 0 always wins a tie.
module mem_arbiter #(
   parameter int LAT = 4,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic            clk,
   input  logic            reset_in_n,
   input  logic            req0,
   input  logic            req1,
   input  logic            we0,
   input  logic            we1,
   input  logic [AW-1:0]   addr0,
   input  logic [AW-1:0]   addr1,
   input  logic [DW-1:0]   wdata0,
   input  logic [DW-1:0]   wdata1,
   input  logic [DW/8-1:0] be0,
   input  logic [DW/8-1:0] be1,
   output logic            gnt0,
   output logic            gnt1,
   output logic            done0,
   output logic            done1,
   output logic [DW-1:0]   rdata,
   output logic            busy,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata
);

   localparam logic [2:0] LAT3 = 3'(LAT);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic [2:0]        cnt, cnt_nxt;
   logic              own;
   logic              we_q;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     wdata_q;
   logic [DW/8-1:0]   be_q;
   logic [DW-1:0]     rdata_q;
   logic              arb;
   logic              win;
   logic              last_acc;

`ifdef MEM_ARB_RR_EN
   logic              last;
   assign win = (req0 && req1) ? ~last : req1;
`else
   assign win = ~req0 & req1;
`endif

   // Requests are only looked at outside ACCESS.
   assign arb      = (state != ACCESS) && (req0 || req1);
   assign last_acc = (state == ACCESS) && (cnt == LAT3);

   always_ff @(posedge clk or negedge reset_in_n) begin
      if (!reset_in_n) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      rdata     = '0;
      busy      = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      case (state)
         IDLE: begin
            if (arb) begin
               state_nxt = ACCESS;
               cnt_nxt   = 3'd1;
            end
         end
         ACCESS: begin
            busy      = 1'b1;
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_be    = be_q;
            gnt0      = (cnt == 3'd1) && !own;
            gnt1      = (cnt == 3'd1) && own;
            if (cnt == LAT3) begin
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         RESP: begin
            busy  = 1'b1;
            done0 = !own;
            done1 = own;
            rdata = rdata_q;
            if (arb) begin
               state_nxt = ACCESS;
               cnt_nxt   = 3'd1;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = 3'd0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_in_n) begin
      if (!reset_in_n) begin
         own     <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last    <= 1'b1;
`endif
      end else begin
         if (arb) begin
            own     <= win;
            we_q    <= win ? we1    : we0;
            addr_q  <= win ? addr1  : addr0;
            wdata_q <= win ? wdata1 : wdata0;
            be_q    <= win ? be1    : be0;
`ifdef MEM_ARB_RR_EN
            last    <= win;
`endif
         end
         if (last_acc) begin
            rdata_q <= we_q ? '0 : mem_rdata;
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single-ported data memory. It shares the memory between two requesters: port 0 is the load/store unit and port 1 is the fetch/debug side. It grants one access at a time and holds address, data and write strobes stable for the memory's fixed access latency. It then returns the read word with a one-cycle done pulse. It sits between the requesters and the data memory and replaces the ad-hoc latency counting previously embedded in each requester.

## Interface
- `LAT`, 4: memory access latency in cycles; legal range 2..7.
- `AW`, 32: address width.
- `DW`, 32: data width; byte enables are DW/8 wide.
- `clk`  in  1  single clock; all state changes on posedge.
- `reset_in_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held high until the matching `gnt` is seen.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  AW  byte address.
- `wdata0` / `wdata1`  in  DW  write data.
- `be0` / `be1`  in  DW/8  byte enables.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: the request has been accepted.
- `done0` / `done1`  out  1  one-cycle pulse: the access is complete and `rdata` is valid.
- `rdata`  out  DW  read data, valid only while a `done` is high; 0 otherwise.
- `busy`  out  1  high in ACCESS and RESP.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_be`  out  DW/8  memory byte enables.
- `mem_rdata`  in  DW  memory read data, valid on the LAT-th ACCESS cycle.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **Counter:** 3-bit `cnt`.
- **Owner register:** `own` (0 or 1).
- **Priority pointer:** `last`.
- **Latched request:** we, addr, wdata, be.
- **Arbitration** happens only at the posedge in IDLE or RESP when `req0 | req1` is high.
  - The winner is latched into `own` and the request registers.
  - The FSM moves to ACCESS with `cnt` = 1.
  - `gnt<own>` is high for the first ACCESS cycle only.
- **ACCESS:**
  - `mem_en` = 1.
  - `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are driven from the latched registers and held constant.
  - `cnt` increments each cycle.
  - Requests are ignored.
- **Leaving ACCESS:** at the posedge with `cnt == LAT`:
  - `mem_rdata` is captured into the `rdata` register; a write captures 0.
  - The FSM moves to RESP.
- **RESP:**
  - `done<own>` = 1 and `rdata` is driven.
  - All `mem_*` outputs are 0.
  - Arbitration occurs as in IDLE; with no request the FSM returns to IDLE.
- **Outside ACCESS:** all `mem_*` outputs are 0.
- **`last`:** updated to `own` at each grant.
- **Requester rule:** drop or replace `req` after seeing `gnt`. Since LAT ≥ 2, `req` is not resampled before RESP.
- **Single requester:** that port is always granted.

## Timing
- **Reset value of every output:** 0. State = IDLE, `cnt` = 0, `last` = 1, so port 0 wins the first tie.
- **Grant latency:** `req` is sampled at edge E; `gnt` is high during cycle E..E+1.
- **Done latency:** `done` is high during cycle E+LAT..E+LAT+1.
- **Throughput:** a back-to-back access (new request already pending during RESP) is granted at edge E+LAT+1. One access completes every LAT+1 cycles.
- **Reset mid-access:** `reset_in_n` low at any time aborts the access immediately. No `done` is issued and `mem_en` drops asynchronously.
- **`cnt` range:** never exceeds LAT and never wraps.

## Configuration
- `MEM_ARB_RR_EN`:
  - Defined: on a simultaneous `req0` and `req1`, the port ≠ `last` is granted (round-robin).
  - Undefined: port 0 always wins a tie, `last` is not implemented, and port 1 can starve.

## Test plan
- **Single read:** LAT=4; `req0`=1, `we0`=0, `addr0`=0x100, with memory returning 0xDEADBEEF. Expect `gnt0` 1 cycle after sampling, `mem_en` high 4 cycles with `mem_addr`=0x100, then `done0` with `rdata`=0xDEADBEEF; `done1` stays 0.
- **Single write:** `req1`=1, `we1`=1, `addr1`=0x20, `wdata1`=0x12345678, `be1`=4'b0011. Expect `mem_we`=1, `mem_be`=0011 and `mem_wdata`=0x12345678 stable for 4 cycles, `done1` pulse, `rdata`=0.
- **Contention with `MEM_ARB_RR_EN`:** `req0` and `req1` held high continuously. Expect grants alternating 0,1,0,1, with a grant every 5 cycles (LAT=4). Without the macro, expect 0,0,0.
- **Back-to-back:** `req0` re-raised during RESP. Expect ACCESS re-entered directly with no IDLE cycle, and `busy` continuously high.
- **Reset mid-access:** `reset_in_n` pulled low at `cnt`=2. Expect all outputs 0 immediately, no `done`, and the FSM in IDLE after release.
- **Request during ACCESS:** `req1` raised while port 0's access is in flight. Expect no `gnt1` until the RESP edge, then `gnt1` in the following cycle.
